// File: rtl/host_frame_parser.sv
// host_frame_parser
// Parses the host->FPGA command stream. Each frame is a destination word, a
// command word, an optional 24-bit length and checksum (full frames) and a
// payload that is forwarded with zero latency to the addressed slot(s).
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   in_data_i/in_ready_i    word from host FIFO / FIFO not empty
//   in_enable_o             parser takes the word this cycle
//   lookup_cmd_o            command byte to the external decode table
//   lookup_simple_i/len_i   table result: simple framing / simple length
//   out_data_o ... out_enable_o, out_ready_i   payload stream to the slots
//   frame_done_o            pulse: frame completed cleanly
//   frame_error_o           pulse: frame aborted or bad
//   err_code_o              1 bad dest, 2 checksum, 3 timeout (held)
//   err_count_o             saturating error count
module host_frame_parser #(
    parameter int HOST_WIDTH     = 16,
    parameter int NUM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [HOST_WIDTH-1:0] in_data_i,
    input  logic                  in_ready_i,
    output logic                  in_enable_o,
    output logic [7:0]            lookup_cmd_o,
    input  logic                  lookup_simple_i,
    input  logic [3:0]            lookup_len_i,
    output logic [HOST_WIDTH-1:0] out_data_o,
    output logic [7:0]            out_cmd_o,
    output logic [NUM_SLOTS-1:0]  out_slot_mask_o,
    output logic                  out_first_o,
    output logic                  out_last_o,
    output logic                  out_enable_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o,
    output logic                  frame_error_o,
    output logic [1:0]            err_code_o,
    output logic [15:0]           err_count_o
);

    typedef enum logic [2:0] {
        ST_DEST    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_LEN_LO  = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CSUM_HI = 3'd5,
        ST_CSUM_LO = 3'd6
    } state_e;

    localparam logic [15:0]          TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]           SLOTS_B   = 8'(NUM_SLOTS);
    localparam logic [NUM_SLOTS-1:0] MASK_ONE  = NUM_SLOTS'(1);
    localparam logic [NUM_SLOTS-1:0] MASK_ALL  = {NUM_SLOTS{1'b1}};
    localparam logic [NUM_SLOTS-1:0] MASK_NONE = {NUM_SLOTS{1'b0}};

    // 32-bit wrap-around checksum step over the low 16 bits of a word.
    function automatic logic [31:0] csum_add(input logic [31:0] acc,
                                             input logic [15:0] word);
        csum_add = acc + {16'd0, word};
    endfunction

    state_e                 state_q;
    logic [7:0]             cmd_q;
    logic [NUM_SLOTS-1:0]   mask_q;
    logic                   drop_q;
    logic                   simple_q;
    logic                   first_q;
    logic [23:0]            remain_q;
    logic [31:0]            csum_q;
    logic [15:0]            csum_hi_q;
    logic [15:0]            tmo_q;
    logic                   frame_done_q;
    logic                   frame_error_q;
    logic [1:0]             err_code_q;
    logic [15:0]            err_count_q;

    logic                   fwd_s;
    logic                   in_enable_s;
    logic                   in_xfer_s;
    logic                   out_enable_s;
    logic                   tmo_hit_s;
    logic                   fin_s;
    logic [1:0]             fin_code_s;
    logic [23:0]            len_simple_s;

    // Handshake steering: payload passes straight through, header words are always taken.
    always_comb begin
        fwd_s        = (state_q == ST_PAYLOAD) && !drop_q;
        in_enable_s  = fwd_s ? out_ready_i : 1'b1;
        in_xfer_s    = in_ready_i && in_enable_s;
        out_enable_s = fwd_s && in_ready_i;
        tmo_hit_s    = (state_q != ST_DEST) && !in_xfer_s && (tmo_q == TMO_LAST);
        len_simple_s = (lookup_len_i == 4'd0) ? 24'd1 : {20'd0, lookup_len_i};
    end

    // End-of-frame detection; a dropped frame reports bad destination ahead of checksum.
    always_comb begin
        fin_s      = 1'b0;
        fin_code_s = 2'd0;
        if (tmo_hit_s) begin
            fin_s      = 1'b1;
            fin_code_s = 2'd3;
        end else if (in_xfer_s && (state_q == ST_PAYLOAD) && simple_q && (remain_q == 24'd1)) begin
            fin_s      = 1'b1;
            fin_code_s = drop_q ? 2'd1 : 2'd0;
        end else if (in_xfer_s && (state_q == ST_CSUM_LO)) begin
            fin_s = 1'b1;
            if (drop_q) begin
                fin_code_s = 2'd1;
            end else if (csum_q != {csum_hi_q, in_data_i[15:0]}) begin
                fin_code_s = 2'd2;
            end else begin
                fin_code_s = 2'd0;
            end
        end else begin
            fin_s      = 1'b0;
            fin_code_s = 2'd0;
        end
    end

    // Frame FSM with header latches, checksum, timeout and status registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_DEST;
            cmd_q         <= 8'd0;
            mask_q        <= MASK_NONE;
            drop_q        <= 1'b0;
            simple_q      <= 1'b0;
            first_q       <= 1'b0;
            remain_q      <= 24'd0;
            csum_q        <= 32'd0;
            csum_hi_q     <= 16'd0;
            tmo_q         <= 16'd0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            err_code_q    <= 2'd0;
            err_count_q   <= 16'd0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;

            if ((state_q == ST_DEST) || in_xfer_s) begin
                tmo_q <= 16'd0;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (in_xfer_s) begin
                case (state_q)
                    ST_DEST: begin
                        if (in_data_i[7:0] == 8'hFF) begin
                            mask_q <= MASK_ALL;
                            drop_q <= 1'b0;
                        end else if (in_data_i[7:0] < SLOTS_B) begin
                            mask_q <= MASK_ONE << in_data_i[2:0];
                            drop_q <= 1'b0;
                        end else begin
                            mask_q <= MASK_NONE;
                            drop_q <= 1'b1;
                        end
                        csum_q  <= 32'd0;
                        first_q <= 1'b1;
                        state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        cmd_q <= in_data_i[7:0];
                        if (lookup_simple_i) begin
                            simple_q <= 1'b1;
                            remain_q <= len_simple_s;
                            state_q  <= ST_PAYLOAD;
                        end else begin
                            simple_q <= 1'b0;
                            state_q  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        remain_q[23:16] <= in_data_i[7:0];
                        state_q         <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        remain_q[15:0] <= in_data_i[15:0];
                        if ({remain_q[23:16], in_data_i[15:0]} == 24'd0) begin
                            state_q <= ST_CSUM_HI;
                        end else begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        csum_q   <= csum_add(csum_q, in_data_i[15:0]);
                        first_q  <= 1'b0;
                        remain_q <= remain_q - 24'd1;
                        if (remain_q == 24'd1) begin
                            state_q <= simple_q ? ST_DEST : ST_CSUM_HI;
                        end else begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_CSUM_HI: begin
                        csum_hi_q <= in_data_i[15:0];
                        state_q   <= ST_CSUM_LO;
                    end
                    ST_CSUM_LO: begin
                        state_q <= ST_DEST;
                    end
                    default: begin
                        state_q <= ST_DEST;
                    end
                endcase
            end else if (tmo_hit_s) begin
                // Abandon the frame; any forwarded words are left without out_last.
                state_q <= ST_DEST;
            end else begin
                state_q <= state_q;
            end

            if (fin_s) begin
                if (fin_code_s == 2'd0) begin
                    frame_done_q <= 1'b1;
                end else begin
                    frame_error_q <= 1'b1;
                    err_code_q    <= fin_code_s;
                    if (err_count_q != 16'hFFFF) begin
                        err_count_q <= err_count_q + 16'd1;
                    end else begin
                        err_count_q <= err_count_q;
                    end
                end
            end else begin
                err_code_q <= err_code_q;
            end
        end
    end

    assign in_enable_o     = in_enable_s;
    assign lookup_cmd_o    = (state_q == ST_CMD) ? in_data_i[7:0] : cmd_q;
    assign out_enable_o    = out_enable_s;
    assign out_data_o      = out_enable_s ? in_data_i : {HOST_WIDTH{1'b0}};
    assign out_first_o     = out_enable_s && first_q;
    assign out_last_o      = out_enable_s && (remain_q == 24'd1);
    assign out_cmd_o       = cmd_q;
    assign out_slot_mask_o = mask_q;
    assign frame_done_o    = frame_done_q;
    assign frame_error_o   = frame_error_q;
    assign err_code_o      = err_code_q;
    assign err_count_o     = err_count_q;

endmodule
